// File: rtl/sevenseg_scan_ctrl.sv
// Eight-digit common-anode seven-segment scanner: double-buffered digit store,
// one digit per slot, PWM brightness within the slot, optional leading-zero blanking.
module sevenseg_scan_ctrl #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int FRAME_HZ = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       blank_lz,
    input  logic [2:0] brightness,
    output logic [7:0] anode_assert,
    output logic [6:0] segs,
    output logic       frame_start
);
    localparam int SUB_CYC = CLK_HZ / (FRAME_HZ * 64);
    localparam int PW      = (SUB_CYC > 1) ? $clog2(SUB_CYC) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]      state_q;
    logic [7:0][3:0] shadow_q, active_q, view;
    logic [2:0]      idx_q, sub_q;
    logic [PW-1:0]   presc_q;
    logic [7:0]      zero_from;
    logic            frame_copy, blanked, lit, presc_last;
    logic [6:0]      seg_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;  default: decode = 7'h0E;
        endcase
    endfunction

    // On the frame-start edge the output register must already see the freshly
    // copied frame, so drive from the shadow directly for that one cycle.
    assign frame_copy = (state_q == SCAN) && enable &&
                        (idx_q == 3'd0) && (sub_q == 3'd0) && (presc_q == '0);
    assign view       = frame_copy ? shadow_q : active_q;
    assign presc_last = (presc_q == PW'(SUB_CYC - 1));

    always_comb begin
        logic above;
        zero_from = '0;
        above     = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            above        = above && (view[i] == 4'd0);
            zero_from[i] = above;
        end
    end

    assign blanked  = blank_lz && (idx_q != 3'd0) && zero_from[idx_q];
    assign lit      = (sub_q <= brightness) && !blanked;
    assign seg_next = decode(view[idx_q]);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            active_q     <= '0;
            idx_q        <= '0;
            sub_q        <= '0;
            presc_q      <= '0;
            anode_assert <= 8'hFF;
            segs         <= 7'h7F;
            frame_start  <= 1'b0;
        end else begin
            if (wr_en)
                shadow_q[wr_addr] <= wr_data;
            anode_assert <= 8'hFF;
            segs         <= 7'h7F;
            frame_start  <= 1'b0;
            case (state_q)
                IDLE: begin
                    idx_q   <= '0;
                    sub_q   <= '0;
                    presc_q <= '0;
                    if (enable)
                        state_q <= SCAN;
                end
                default: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        sub_q   <= '0;
                        presc_q <= '0;
                    end else begin
                        if (frame_copy) begin
                            active_q    <= shadow_q;
                            frame_start <= 1'b1;
                        end
                        if (lit) begin
                            anode_assert <= ~(8'd1 << idx_q);
                            segs         <= seg_next;
                        end
                        if (presc_last) begin
                            presc_q <= '0;
                            sub_q   <= sub_q + 3'd1;
                            if (sub_q == 3'd7)
                                idx_q <= idx_q + 3'd1;
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Time-multiplexing scan controller for the 8-digit common-anode seven-segment display. It holds a double-buffered digit store written by the stopwatch/counter datapath, and sequences the anodes one digit at a time. It applies PWM brightness and optional leading-zero blanking, and drives `anode_assert`/`segs` at the top level in place of ad-hoc scan logic.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency.
- `FRAME_HZ`, 1000, full 8-digit refresh rate. `SUB_CYC = CLK_HZ/(FRAME_HZ*64)`, truncated, must be ≥1. Slot = 8·SUB_CYC cycles; frame = 64·SUB_CYC cycles.
- `clock  in  1`  sole clock.
- `reset  in  1`  synchronous, active-high.
- `enable  in  1`  scanning enabled; 0 blanks the display.
- `wr_en  in  1`  write strobe into shadow digit buffer.
- `wr_addr  in  3`  digit index; 0 = rightmost/least significant.
- `wr_data  in  4`  hex nibble.
- `blank_lz  in  1`  1 = suppress leading zeros.
- `brightness  in  3`  on-time = (brightness+1)/8 of each slot.
- `anode_assert  out  8`  active-low, at most one bit low.
- `segs  out  7`  active-low; bit0=a … bit6=g.
- `frame_start  out  1`  one-cycle pulse when digit 0's slot begins.

## Operation
- Reset:
  - shadow and active buffers cleared to 0; digit index 0; sub-phase 0; prescaler 0.
  - State = IDLE; `anode_assert`=8'hFF, `segs`=7'h7F, `frame_start`=0.
- FSM:
  - IDLE → SCAN when `enable`=1.
  - SCAN → IDLE when `enable`=0.
  - Entering IDLE resets index, sub-phase and prescaler, and forces outputs off.
- Prescaler counts 0..SUB_CYC-1 and ticks sub-phase 0..7. Sub-phase wrap advances the digit index 0→1→…→7→0.
- Slot start for digit 0:
  - active buffer ← shadow buffer, all 8 nibbles at once.
  - `frame_start` pulses.
- Writes:
  - `wr_en` writes `wr_data` to shadow[`wr_addr`] every cycle, in any state.
  - A write on the same edge as a frame copy is not included in that copy; it appears at the next frame. Writes never alter the frame in progress.
- Digit drive, in SCAN, for current index i:
  - lit when sub-phase ≤ `brightness` and digit i is not blanked → `anode_assert` bit i low, `segs` = decode(active[i]).
  - otherwise `anode_assert`=8'hFF, `segs`=7'h7F.
- Blanking: with `blank_lz`=1, digit i (i≥1) is blanked if active[i..7] are all zero. Digit 0 is never blanked.
- Decode, active-low `{g,f,e,d,c,b,a}`:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- `brightness` and `blank_lz` are sampled live each cycle; no shadowing.

## Timing
- All outputs registered; combinational paths to outputs are not allowed.
- `enable` first sampled 1 at edge N:
  - at edge N+1, digit 0 slot starts, `frame_start`=1, frame copy done.
  - digit 0 drive is visible from N+1.
- Each slot lasts exactly 8·SUB_CYC cycles. Digit i slot starts at N+1+i·8·SUB_CYC; the frame period is 64·SUB_CYC.
- Lit window per slot: (brightness+1)·SUB_CYC cycles, starting at slot start.
- `enable` sampled 0 at edge M: outputs off at M+1. Re-enable restarts from digit 0 with a fresh `frame_start`.
- `reset` mid-frame: at the next edge, full reset state takes effect regardless of `enable`. Buffers are cleared.
- Write-to-display latency: the display shows a write from the first frame copy strictly after the write edge.

## Test plan
Parameters for all scenarios: CLK_HZ=64, FRAME_HZ=1 → SUB_CYC=1, slot=8, frame=64 cycles.
- Reset, enable=0 → `anode_assert`=FF, `segs`=7F, `frame_start`=0 indefinitely.
- Write digits 0..7 = 0..7, brightness=7, blank_lz=0, enable=1 → `anode_assert` FE, FD, FB…7F, each held 8 cycles. `segs` 40, 79, 24, 30, 19, 12, 02, 78. `frame_start` pulses every 64 cycles.
- brightness=2 → each anode low for 3 cycles then FF for 5; `segs`=7F during the off cycles.
- Buffer = 0x00000305, blank_lz=1 → digits 0..2 lit (12, 40, 30); digits 3..7 anodes stay high. Buffer all zero → only digit 0 lit showing 40.
- Write digit 0 = 8 on the `frame_start` edge, then mid-frame → display holds the old value for the current frame; 00 appears from the next frame.
- Reset asserted mid-slot of digit 5 → next cycle outputs FF/7F. After release with enable=1, scanning restarts at digit 0 showing 40.
